// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants, PC-unit FSM state and branch-offset helper.
package cpu_pkg;

    localparam logic [31:0] RESET_ADDR = 32'h0000_3000;
    localparam logic [31:0] EXC_ADDR   = 32'h0000_4180;
    localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } pc_state_t;

    // Word offset to byte offset, sign-extended wide enough for any caller.
    function automatic logic [63:0] sext_sh2(input logic [15:0] imm);
        return {{46{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/npc_mux.sv
// npc_mux: combinational next-PC select, target arithmetic and EPC/FSM update.
module npc_mux
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] EXC_ADDR = ADDR_W'(cpu_pkg::EXC_ADDR)
) (
    input  pc_state_t         state,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] epc,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] id_pc,
    input  logic [15:0]       imm16,
    input  logic              j_en,
    input  logic [25:0]       j_index,
    input  logic              jr_en,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              jr_bad,
    input  logic              exc_req,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              eret,
    output logic [ADDR_W-1:0] npc,
    output logic              epc_we,
    output logic [ADDR_W-1:0] epc_d,
    output pc_state_t         state_d,
    output logic              fault_d
);

    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] id_p4;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] j_tgt;
    logic [ADDR_W-1:0] jr_tgt;

    assign seq    = pc + ADDR_W'(4);
    assign id_p4  = id_pc + ADDR_W'(4);
    assign br_tgt = id_p4 + ADDR_W'(sext_sh2(imm16));
    assign j_tgt  = {id_p4[ADDR_W-1:28], j_index, 2'b00};
    assign jr_tgt = {jr_target[ADDR_W-1:2], 2'b00};

    always_comb begin
        npc     = seq;
        epc_we  = 1'b0;
        epc_d   = exc_pc;
        state_d = state;
        fault_d = 1'b0;
        if (state == RUN && exc_req) begin
            npc     = EXC_ADDR;
            epc_we  = 1'b1;
            state_d = HANDLER;
        end else if (state == HANDLER && eret) begin
            npc     = epc;
            state_d = RUN;
        end else if (stall) begin
            npc = pc;
        end else if (jr_en && jr_bad) begin
            // A bad jr inside the handler only flags; it never nests.
            fault_d = 1'b1;
            if (state == RUN) begin
                npc     = EXC_ADDR;
                epc_we  = 1'b1;
                epc_d   = jr_target;
                state_d = HANDLER;
            end
        end else if (jr_en) begin
            npc = jr_tgt;
        end else if (j_en) begin
            npc = j_tgt;
        end else if (br_taken) begin
            npc = br_tgt;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: IF-stage fetch PC, EPC and RUN/HANDLER FSM for the pipelined core.
// Optional jr target checking is enabled by defining ALIGN_CHECK_EN.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(cpu_pkg::RESET_ADDR),
    parameter logic [ADDR_W-1:0] EXC_ADDR   = ADDR_W'(cpu_pkg::EXC_ADDR),
    parameter logic [ADDR_W-1:0] IMEM_BASE  = ADDR_W'(cpu_pkg::IMEM_BASE),
    parameter int                IDX_W      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] id_pc,
    input  logic [15:0]       imm16,
    input  logic              j_en,
    input  logic [25:0]       j_index,
    input  logic              jr_en,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              exc_req,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              eret,
    output logic [ADDR_W-1:0] pc,
    output logic [IDX_W-1:0]  pc_idx,
    output logic [ADDR_W-1:0] pc_plus8,
    output logic [ADDR_W-1:0] epc,
    output logic              in_handler,
    output logic              fault
);

    pc_state_t         state;
    pc_state_t         state_d;
    logic [ADDR_W-1:0] npc;
    logic [ADDR_W-1:0] epc_d;
    logic [ADDR_W-1:0] off;
    logic              epc_we;
    logic              fault_d;
    logic              jr_bad;

    assign off        = pc - IMEM_BASE;
    assign pc_idx     = IDX_W'(off >> 2);
    assign pc_plus8   = pc + ADDR_W'(8);
    assign in_handler = (state == HANDLER);

`ifdef ALIGN_CHECK_EN
    logic [ADDR_W-1:0] jr_off;

    // Below-base targets wrap to a huge offset and fail the window test.
    assign jr_off = jr_target - IMEM_BASE;
    assign jr_bad = (jr_target[1:0] != 2'b00)
                 || ((jr_off >> (IDX_W + 2)) != '0);
`else
    assign jr_bad = 1'b0;
`endif

    npc_mux #(
        .ADDR_W   (ADDR_W),
        .EXC_ADDR (EXC_ADDR)
    ) u_npc_mux (
        .state     (state),
        .pc        (pc),
        .epc       (epc),
        .stall     (stall),
        .br_taken  (br_taken),
        .id_pc     (id_pc),
        .imm16     (imm16),
        .j_en      (j_en),
        .j_index   (j_index),
        .jr_en     (jr_en),
        .jr_target (jr_target),
        .jr_bad    (jr_bad),
        .exc_req   (exc_req),
        .exc_pc    (exc_pc),
        .eret      (eret),
        .npc       (npc),
        .epc_we    (epc_we),
        .epc_d     (epc_d),
        .state_d   (state_d),
        .fault_d   (fault_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_ADDR;
            epc   <= '0;
            state <= RUN;
            fault <= 1'b0;
        end else begin
            pc    <= npc;
            state <= state_d;
            fault <= fault_d;
            if (epc_we) begin
                epc <= epc_d;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: table vectors, corner sequences and random stimulus for pc_unit,
// checked against a behavioural next-PC model.
module tb_pc_unit;

`ifdef ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, br_taken, j_en, jr_en, exc_req, eret;
    logic [31:0] id_pc, jr_target, exc_pc;
    logic [15:0] imm16;
    logic [25:0] j_index;
    logic [31:0] pc, pc_plus8, epc;
    logic [9:0]  pc_idx;
    logic        in_handler, fault;

    pc_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_taken   (br_taken),
        .id_pc      (id_pc),
        .imm16      (imm16),
        .j_en       (j_en),
        .j_index    (j_index),
        .jr_en      (jr_en),
        .jr_target  (jr_target),
        .exc_req    (exc_req),
        .exc_pc     (exc_pc),
        .eret       (eret),
        .pc         (pc),
        .pc_idx     (pc_idx),
        .pc_plus8   (pc_plus8),
        .epc        (epc),
        .in_handler (in_handler),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] id_pc;
        logic [15:0] imm;
        logic        j;
        logic [25:0] jidx;
        logic        jr;
        logic [31:0] jrt;
        logic        exc;
        logic [31:0] excpc;
        logic        eret;
    } ev_t;

    typedef struct {
        ev_t         ev;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        hand;
        logic        flt;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_pc, m_epc;
    logic        m_hand, m_fault;
    vec_t        vq[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ev_t nop();
        ev_t e = '{default: '0};
        return e;
    endfunction

    function automatic ev_t ev_br(logic [31:0] a, logic [15:0] imm);
        ev_t e = nop();
        e.br = 1'b1; e.id_pc = a; e.imm = imm;
        return e;
    endfunction

    function automatic ev_t ev_j(logic [31:0] a, logic [25:0] idx);
        ev_t e = nop();
        e.j = 1'b1; e.id_pc = a; e.jidx = idx;
        return e;
    endfunction

    function automatic ev_t ev_jr(logic [31:0] t);
        ev_t e = nop();
        e.jr = 1'b1; e.jrt = t;
        return e;
    endfunction

    function automatic ev_t ev_exc(logic [31:0] p);
        ev_t e = nop();
        e.exc = 1'b1; e.excpc = p;
        return e;
    endfunction

    function automatic ev_t ev_eret();
        ev_t e = nop();
        e.eret = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] idx_of(logic [31:0] a);
        return ((a - 32'h3000) / 4) % 1024;
    endfunction

    function automatic logic jr_faults(logic [31:0] t);
        return ALIGN && ((t % 4) != 0 || t < 32'h3000 || t >= 32'h4000);
    endfunction

    task automatic add(ev_t e, logic [31:0] p, logic [31:0] ep,
                       logic h, logic f);
        vec_t v;
        v.ev = e; v.pc = p; v.epc = ep; v.hand = h; v.flt = f;
        vq.push_back(v);
    endtask

    task automatic model_reset();
        m_pc = 32'h3000; m_epc = 0; m_hand = 1'b0; m_fault = 1'b0;
    endtask

    task automatic check_model(string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".epc"}, epc, m_epc);
        chk({tag, ".hand"}, 32'(in_handler), 32'(m_hand));
        chk({tag, ".fault"}, 32'(fault), 32'(m_fault));
        chk({tag, ".idx"}, 32'(pc_idx), idx_of(m_pc));
        chk({tag, ".plus8"}, pc_plus8, m_pc + 8);
    endtask

    // Apply one cycle of inputs, advance the model by the priority rules, compare.
    task automatic step(ev_t e, string tag);
        logic [31:0] off;
        stall = e.stall; br_taken = e.br; id_pc = e.id_pc; imm16 = e.imm;
        j_en = e.j; j_index = e.jidx; jr_en = e.jr; jr_target = e.jrt;
        exc_req = e.exc; exc_pc = e.excpc; eret = e.eret;
        off = {{16{e.imm[15]}}, e.imm};
        m_fault = 1'b0;
        if (!m_hand && e.exc) begin
            m_epc = e.excpc; m_pc = 32'h4180; m_hand = 1'b1;
        end else if (m_hand && e.eret) begin
            m_pc = m_epc; m_hand = 1'b0;
        end else if (e.stall) begin
            m_pc = m_pc;
        end else if (e.jr && jr_faults(e.jrt)) begin
            m_fault = 1'b1;
            if (m_hand) m_pc = m_pc + 4;
            else begin
                m_epc = e.jrt; m_pc = 32'h4180; m_hand = 1'b1;
            end
        end else if (e.jr) begin
            m_pc = e.jrt - (e.jrt % 4);
        end else if (e.j) begin
            m_pc = ((e.id_pc + 4) & 32'hF000_0000) + 32'(e.jidx) * 4;
        end else if (e.br) begin
            m_pc = e.id_pc + 4 + off * 4;
        end else begin
            m_pc = m_pc + 4;
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        ev_t e;
        model_reset();
        reset = 1'b1;
        stall = 0; br_taken = 0; j_en = 0; jr_en = 0; exc_req = 0; eret = 0;
        id_pc = 0; imm16 = 0; j_index = 0; jr_target = 0; exc_pc = 0;
        #2;
        chk("reset.pc", pc, 32'h3000);
        chk("reset.idx", 32'(pc_idx), 0);
        #10 reset = 1'b0;
        for (int i = 0; i < 3; i++) step(nop(), "boot");
        chk("boot.pc", pc, 32'h300C);
        chk("boot.idx", 32'(pc_idx), 3);

        add(ev_br(32'h3008, 16'hFFFE), 32'h3004, 0, 0, 0);
        add(ev_br(32'h3008, 16'h0003), 32'h3018, 0, 0, 0);
        e = ev_jr(32'h3040); e.j = 1; e.jidx = 26'h0C01; e.id_pc = 32'h3008;
        add(e, 32'h3040, 0, 0, 0);
        add(ev_j(32'h3008, 26'h0C01), 32'h3004, 0, 0, 0);
        e = ev_j(32'h3008, 26'h0C01); e.stall = 1;
        add(e, 32'h3004, 0, 0, 0);
        e = ev_exc(32'h3020); e.stall = 1;
        add(e, 32'h4180, 32'h3020, 1, 0);
        add(ev_exc(32'h3100), 32'h4184, 32'h3020, 1, 0);
        add(ev_eret(), 32'h3020, 32'h3020, 0, 0);
        add(ev_eret(), 32'h3024, 32'h3020, 0, 0);
        e = ev_jr(32'h3040); e.stall = 1; e.br = 1;
        add(e, 32'h3024, 32'h3020, 0, 0);
        add(ev_br(32'h3000, 16'h8000), 32'hFFFE_3004, 32'h3020, 0, 0);
        add(nop(), 32'hFFFE_3008, 32'h3020, 0, 0);
`ifdef ALIGN_CHECK_EN
        add(ev_jr(32'h3042), 32'h4180, 32'h3042, 1, 1);
        add(ev_eret(), 32'h3042, 32'h3042, 0, 0);
        add(ev_jr(32'h5000), 32'h4180, 32'h5000, 1, 1);
        add(nop(), 32'h4184, 32'h5000, 1, 0);
        add(ev_jr(32'h3001), 32'h4188, 32'h5000, 1, 1);
`else
        add(ev_jr(32'h3042), 32'h3040, 32'h3020, 0, 0);
        add(ev_jr(32'h5000), 32'h5000, 32'h3020, 0, 0);
        add(nop(), 32'h5004, 32'h3020, 0, 0);
        add(nop(), 32'h5008, 32'h3020, 0, 0);
        add(ev_jr(32'h3001), 32'h3000, 32'h3020, 0, 0);
`endif

        foreach (vq[i]) begin
            step(vq[i].ev, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.pc", i), pc, vq[i].pc);
            chk($sformatf("vec%0d.epc", i), epc, vq[i].epc);
            chk($sformatf("vec%0d.hand", i), 32'(in_handler), 32'(vq[i].hand));
            chk($sformatf("vec%0d.fault", i), 32'(fault), 32'(vq[i].flt));
        end

        step(ev_eret(), "wrap0");
        step(ev_br(32'hFFFF_FFF8, 16'h0000), "wrap1");
        chk("wrap.top", pc, 32'hFFFF_FFFC);
        chk("wrap.plus8", pc_plus8, 32'h4);
        step(nop(), "wrap2");
        chk("wrap.zero", pc, 32'h0);

        for (int n = 0; n < 400; n++) begin
            e = nop();
            e.stall = ($urandom_range(0, 4) == 0);
            e.br    = ($urandom_range(0, 3) == 0);
            e.j     = ($urandom_range(0, 4) == 0);
            e.jr    = ($urandom_range(0, 4) == 0);
            e.exc   = ($urandom_range(0, 7) == 0);
            e.eret  = ($urandom_range(0, 5) == 0);
            e.id_pc = 32'h3000 + 4 * $urandom_range(0, 2047);
            if ($urandom_range(0, 7) == 0) e.id_pc = $urandom;
            e.imm   = 16'($urandom);
            e.jidx  = 26'($urandom);
            e.excpc = $urandom;
            case ($urandom_range(0, 4))
                0: e.jrt = 32'h3000 + 4 * $urandom_range(0, 1023);
                1: e.jrt = 32'h3000 + $urandom_range(0, 4095);
                2: e.jrt = 32'h4000;
                3: e.jrt = 32'h2FFC;
                default: e.jrt = $urandom;
            endcase
            step(e, "rand");
        end

        step(ev_eret(), "tail0");
        step(ev_br(32'h300C, 16'h0000), "tail1");
        chk("tail.pc", pc, 32'h3010);
        #3 reset = 1'b1;
        model_reset();
        #1;
        chk("midreset.pc", pc, 32'h3000);
        chk("midreset.idx", 32'(pc_idx), 0);
        chk("midreset.epc", epc, 0);
        chk("midreset.hand", 32'(in_handler), 0);
        chk("midreset.fault", 32'(fault), 0);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) step(nop(), "rel");
        chk("rel.pc", pc, 32'h300C);
        chk("rel.idx", 32'(pc_idx), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised fetch-address generator for the pipelined MIPS core and successor to the single-cycle PC. It holds the fetch PC and resolves next-PC from stall, branch, j/jal, jr, exception entry and eret. It produces both the byte address and the IMEM word index, and keeps the EPC. It sits at the IF stage, driven by ID-stage branch/jump resolution and the coprocessor-0 exception request.

Parameters:
ADDR_W, 32, PC/address width in bits
RESET_ADDR, 32'h0000_3000, PC value after reset
EXC_ADDR, 32'h0000_4180, exception vector
IMEM_BASE, 32'h0000_3000, byte address of IMEM word 0
IDX_W, 10, IMEM word-index width (IMEM depth = 2**IDX_W words)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
stall  in  1  hold PC (load-use hazard)
br_taken  in  1  ID-stage branch taken
id_pc  in  ADDR_W  PC of the instruction in ID (branch/jump owner)
imm16  in  16  branch offset in words
j_en  in  1  j/jal in ID
j_index  in  26  jump instr_index
jr_en  in  1  jr/jalr in ID
jr_target  in  ADDR_W  forwarded rs value
exc_req  in  1  exception/interrupt request
exc_pc  in  ADDR_W  PC to save in EPC
eret  in  1  eret in ID
pc  out  ADDR_W  current fetch byte address
pc_idx  out  IDX_W  (pc - IMEM_BASE) >> 2, truncated to IDX_W
pc_plus8  out  ADDR_W  pc + 8 (link value)
epc  out  ADDR_W  saved exception PC
in_handler  out  1  FSM in HANDLER state
fault  out  1  one-cycle fetch-fault pulse (ALIGN_CHECK_EN only; tied 0 otherwise)

Behaviour:
- Reset is asynchronous and active-high: pc=RESET_ADDR, epc=0, FSM=RUN, fault=0. This is immediate, without waiting for a clk edge.
- pc_idx and pc_plus8 are combinational from pc. All other state updates on the posedge clk.
- FSM states:
  - RUN: exc_req -> HANDLER.
  - HANDLER: eret -> RUN. exc_req is ignored (no nesting).
  - eret in RUN is ignored and is treated as no redirect.
- Next-PC priority, highest first:
  1. exc_req (RUN only): pc<=EXC_ADDR, epc<=exc_pc.
  2. eret (HANDLER only): pc<=epc.
  3. stall: pc holds.
  4. jr_en: pc<=jr_target with bits[1:0] forced to 0.
  5. j_en: pc<={id_pc_plus4[ADDR_W-1:28], j_index, 2'b00}, where id_pc_plus4 = id_pc+4.
  6. br_taken: pc<=id_pc + 4 + (sext(imm16) << 2).
  7. Otherwise pc<=pc+4.
- exc_req overrides stall. A redirect under stall is dropped; the ID stage re-asserts it next cycle.
- Arithmetic is modulo 2**ADDR_W: pc+4 from 32'hFFFF_FFFC wraps to 0. Negative branch offsets must wrap correctly.
- pc_idx wraps silently for addresses outside the IMEM window.
- If j_en, jr_en and br_taken are asserted together, the priority order above applies and no error is raised.
- Latency: a redirect presented in cycle N is visible on pc after edge N. The delay slot is fetched by the core's existing sequential step.

Optional Feature:
ALIGN_CHECK_EN
- Defined: when jr_en is taken (no higher-priority event) with jr_target[1:0]!=0, or jr_target outside [IMEM_BASE, IMEM_BASE+4*2**IDX_W), the block does not use the target. Instead: pc<=EXC_ADDR, epc<=jr_target, FSM->HANDLER, fault=1 for exactly that cycle. In HANDLER a faulting jr is ignored: pc<=pc+4, fault=1.
- Undefined: no checking; fault is tied to 0; the jr target is used with its low bits masked.

Decomposition:
- Shared package cpu_pkg holds:
  - constants RESET_ADDR, EXC_ADDR, IMEM_BASE;
  - the 1-bit state encoding pc_state_t {RUN=0, HANDLER=1};
  - the sign-extend-shift helper function, reused by the ALU-side branch compare.
- One natural sub-module: npc_mux (combinational next-PC select and target arithmetic). pc_unit keeps the registers and the FSM.

Test Plan:
1. Reset: assert reset mid-cycle with pc=0x3010 -> pc=0x3000 immediately, pc_idx=0, epc=0, in_handler=0. Release, 3 clocks -> pc=0x300C, pc_idx=3.
2. Branch: id_pc=0x3008, imm16=16'hFFFE, br_taken=1 -> next pc=0x3004. Repeat with imm16=16'h0003 -> next pc=0x3018.
3. Jump/jr priority: j_en=1, j_index=26'h0C01, jr_en=1, jr_target=0x3040 -> next pc=0x3040. Then j_en only -> pc=0x3004. With stall=1 and any redirect -> pc unchanged.
4. Exception round-trip:
   - exc_req=1, exc_pc=0x3020, stall=1 -> pc=0x4180, epc=0x3020, in_handler=1.
   - Second exc_req -> ignored, pc=0x4184.
   - eret -> pc=0x3020, in_handler=0.
   - eret again in RUN -> pc=0x3024.
5. Wrap: force pc=0xFFFF_FFFC, no events -> pc=0x0000_0000. With pc=0x3000, branch id_pc=0x3000, imm16=16'h8000 -> pc=0xFFFE_3004.
6. ALIGN_CHECK_EN builds:
   - jr_target=0x3042 -> pc=0x4180, epc=0x3042, fault pulse 1 cycle.
   - jr_target=0x5000 -> same fault.
   - Without the macro, jr_target=0x3042 -> pc=0x3040, fault=0.
